dmem_access_m: RTL and testbench

- Memory-stage data-memory access controller. Sits directly downstream of the memory-stage control decode and consumes its `dmem_wren` along with the X/M latch outputs.
- Routes each load/store to the FPGA synchronous block RAM or to the memory-mapped I/O port (robot servo/sensor peripherals).
- Generates `stall_M` for multi-cycle accesses and presents load data to the M/W latch.

---
 rtl/dmem_access_m.sv | 196 +++++++++++++++++++
 tb/tb_dmem_access_m.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_m.sv
// Memory-stage data-memory access controller: routes loads/stores to block RAM or MMIO,
// stalls the pipeline for multi-cycle accesses. Optional perf counters: DMEM_PERF_COUNT_EN.
module dmem_access_m #(
   parameter int RD_LAT     = 2,
   parameter int ADDR_W     = 12,
   parameter int IO_SEL_BIT = 16,
   parameter int IO_TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              valid_M,
   input  logic [4:0]        opcode_M,
   input  logic              dmem_wren,
   input  logic [31:0]       addr_M,
   input  logic [31:0]       data_M,
   output logic [ADDR_W-1:0] dmem_address,
   output logic [31:0]       dmem_data,
   output logic              dmem_we,
   input  logic [31:0]       dmem_q,
   output logic              io_req,
   output logic              io_we,
   output logic [7:0]        io_addr,
   output logic [31:0]       io_wdata,
   input  logic [31:0]       io_rdata,
   input  logic              io_ack,
   output logic              stall_M,
   output logic [31:0]       load_data_M,
   output logic              load_valid_M,
   output logic              io_timeout,
   output logic [31:0]       perf_loads,
   output logic [31:0]       perf_stores,
   output logic [31:0]       perf_stalls
);

   typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_WAIT} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [2:0]        wait_reg, wait_next;
   logic [7:0]        io_cnt_reg, io_cnt_next;
   logic              io_req_reg, io_req_next;
   logic              io_we_reg, io_we_next;
   logic [7:0]        io_addr_reg, io_addr_next;
   logic [31:0]       io_wdata_reg, io_wdata_next;
   logic              timeout_reg, timeout_next;

   logic is_load, is_store, is_io;
   logic unused_addr_bits;

   assign is_load  = valid_M && (opcode_M == 5'b01000);
   assign is_store = valid_M && dmem_wren;
   assign is_io    = addr_M[IO_SEL_BIT];
   assign unused_addr_bits = ^addr_M;

   assign io_req     = io_req_reg;
   assign io_we      = io_we_reg;
   assign io_addr    = io_addr_reg;
   assign io_wdata   = io_wdata_reg;
   assign io_timeout = timeout_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         wait_reg     <= '0;
         io_cnt_reg   <= '0;
         io_req_reg   <= 1'b0;
         io_we_reg    <= 1'b0;
         io_addr_reg  <= '0;
         io_wdata_reg <= '0;
         timeout_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         wait_reg     <= wait_next;
         io_cnt_reg   <= io_cnt_next;
         io_req_reg   <= io_req_next;
         io_we_reg    <= io_we_next;
         io_addr_reg  <= io_addr_next;
         io_wdata_reg <= io_wdata_next;
         timeout_reg  <= timeout_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      wait_next     = wait_reg;
      io_cnt_next   = io_cnt_reg;
      io_req_next   = io_req_reg;
      io_we_next    = io_we_reg;
      io_addr_next  = io_addr_reg;
      io_wdata_next = io_wdata_reg;
      timeout_next  = timeout_reg;
      dmem_address  = '0;
      dmem_data     = '0;
      dmem_we       = 1'b0;
      stall_M       = 1'b0;
      load_data_M   = '0;
      load_valid_M  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (is_load || is_store) begin
               if (is_io) begin
                  // A load opcode wins over a stray store strobe
                  io_we_next    = !is_load;
                  io_addr_next  = addr_M[7:0];
                  io_wdata_next = data_M;
                  io_req_next   = 1'b1;
                  io_cnt_next   = 8'd1;
                  stall_M       = 1'b1;
                  state_next    = IO_WAIT;
               end else if (is_load) begin
                  dmem_address = addr_M[ADDR_W-1:0];
                  addr_next    = addr_M[ADDR_W-1:0];
                  wait_next    = 3'(RD_LAT - 1);
                  stall_M      = 1'b1;
                  state_next   = RAM_WAIT;
               end else begin
                  dmem_we      = 1'b1;
                  dmem_address = addr_M[ADDR_W-1:0];
                  dmem_data    = data_M;
               end
            end
         end
         RAM_WAIT: begin
            dmem_address = addr_reg;
            if (wait_reg != 3'd0) begin
               stall_M   = 1'b1;
               wait_next = wait_reg - 3'd1;
            end else begin
               load_valid_M = 1'b1;
               load_data_M  = dmem_q;
               state_next   = IDLE;
            end
         end
         IO_WAIT: begin
            if (io_ack) begin
               load_valid_M = !io_we_reg;
               load_data_M  = io_we_reg ? 32'd0 : io_rdata;
               io_req_next  = 1'b0;
               state_next   = IDLE;
            end else if (io_cnt_reg >= 8'(IO_TIMEOUT)) begin
               // Abort: reads complete with zero data so the pipeline can move on
               load_valid_M = !io_we_reg;
               timeout_next = 1'b1;
               io_req_next  = 1'b0;
               state_next   = IDLE;
            end else begin
               stall_M     = 1'b1;
               io_cnt_next = io_cnt_reg + 8'd1;
            end
         end
         default: state_next = IDLE;
      endcase

      // Combinational outputs must also drop while reset is held
      if (reset) begin
         dmem_address = '0;
         dmem_data    = '0;
         dmem_we      = 1'b0;
         stall_M      = 1'b0;
         load_data_M  = '0;
         load_valid_M = 1'b0;
      end
   end

`ifdef DMEM_PERF_COUNT_EN
   logic [31:0] loads_reg, stores_reg, stalls_reg;
   logic        store_done;

   assign store_done = dmem_we || (state_reg == IO_WAIT && io_we_reg && !stall_M);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         loads_reg  <= '0;
         stores_reg <= '0;
         stalls_reg <= '0;
      end else begin
         if (load_valid_M) loads_reg  <= loads_reg + 32'd1;
         if (store_done)   stores_reg <= stores_reg + 32'd1;
         if (stall_M)      stalls_reg <= stalls_reg + 32'd1;
      end
   end

   assign perf_loads  = loads_reg;
   assign perf_stores = stores_reg;
   assign perf_stalls = stalls_reg;
`else
   assign perf_loads  = 32'd0;
   assign perf_stores = 32'd0;
   assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_access_m.sv
// Directed bench for dmem_access_m: RAM store/load, MMIO read/write, timeout, async reset, perf counters.
module tb_dmem_access_m;

   logic        clock, reset;
   logic        valid_M, dmem_wren;
   logic [4:0]  opcode_M;
   logic [31:0] addr_M, data_M;
   logic [11:0] dmem_address;
   logic [31:0] dmem_data, dmem_q;
   logic        dmem_we;
   logic        io_req, io_we, io_ack;
   logic [7:0]  io_addr;
   logic [31:0] io_wdata, io_rdata;
   logic        stall_M, load_valid_M, io_timeout;
   logic [31:0] load_data_M, perf_loads, perf_stores, perf_stalls;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [4:0] OP_LOAD = 5'b01000;

   dmem_access_m #(.RD_LAT(2), .ADDR_W(12), .IO_SEL_BIT(16), .IO_TIMEOUT(5)) dut (
      .clock(clock), .reset(reset), .valid_M(valid_M), .opcode_M(opcode_M),
      .dmem_wren(dmem_wren), .addr_M(addr_M), .data_M(data_M),
      .dmem_address(dmem_address), .dmem_data(dmem_data), .dmem_we(dmem_we),
      .dmem_q(dmem_q), .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
      .stall_M(stall_M), .load_data_M(load_data_M), .load_valid_M(load_valid_M),
      .io_timeout(io_timeout), .perf_loads(perf_loads), .perf_stores(perf_stores),
      .perf_stalls(perf_stalls)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] op, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      valid_M = v; opcode_M = op; dmem_wren = wr; addr_M = a; data_M = d;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   task automatic txn(input string s);
      $display("txn: %s", s);
   endtask

   initial begin
      reset = 1'b1; idle();
      dmem_q = 32'd0; io_rdata = 32'd0; io_ack = 1'b0;
      tick(); tick();
      mid();
      check("rst_stall", 32'(stall_M), 32'd0);
      check("rst_io_req", 32'(io_req), 32'd0);
      check("rst_lvalid", 32'(load_valid_M), 32'd0);
      check("rst_timeout", 32'(io_timeout), 32'd0);
      check("rst_we", 32'(dmem_we), 32'd0);
      tick(); reset = 1'b0;

      // RAM store, zero latency
      drive(1'b1, 5'd0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5);
      mid();
      check("st_we", 32'(dmem_we), 32'd1);
      check("st_addr", 32'(dmem_address), 32'h010);
      check("st_data", dmem_data, 32'hA5A5_A5A5);
      check("st_stall", 32'(stall_M), 32'd0);
      tick(); txn("RAM store 0x10");
      idle(); mid();
      check("st_we_off", 32'(dmem_we), 32'd0);
      tick();

      // RAM load, RD_LAT=2
      drive(1'b1, OP_LOAD, 1'b0, 32'h0000_0020, 32'd0);
      dmem_q = 32'hDEAD_DEAD;
      mid();
      check("ld_c0_stall", 32'(stall_M), 32'd1);
      check("ld_c0_addr", 32'(dmem_address), 32'h020);
      check("ld_c0_lvalid", 32'(load_valid_M), 32'd0);
      tick(); mid();
      check("ld_c1_stall", 32'(stall_M), 32'd1);
      check("ld_c1_addr", 32'(dmem_address), 32'h020);
      tick(); dmem_q = 32'h1234_5678; mid();
      check("ld_c2_stall", 32'(stall_M), 32'd0);
      check("ld_c2_lvalid", 32'(load_valid_M), 32'd1);
      check("ld_c2_data", load_data_M, 32'h1234_5678);
      tick(); txn("RAM load 0x20");

      // back-to-back store accepted immediately
      drive(1'b1, 5'd0, 1'b1, 32'h0000_0030, 32'h0000_0001);
      mid();
      check("b2b_we", 32'(dmem_we), 32'd1);
      check("b2b_addr", 32'(dmem_address), 32'h030);
      check("b2b_lvalid", 32'(load_valid_M), 32'd0);
      check("b2b_ldata", load_data_M, 32'd0);
      tick(); txn("RAM store 0x30 back-to-back");

      // I/O read, ack on third io_req cycle
      drive(1'b1, OP_LOAD, 1'b0, 32'h0001_0004, 32'd0);
      io_rdata = 32'h0000_BEEF;
      mid();
      check("ior_c0_stall", 32'(stall_M), 32'd1);
      check("ior_c0_req", 32'(io_req), 32'd0);
      tick(); mid();
      check("ior_c1_req", 32'(io_req), 32'd1);
      check("ior_c1_addr", 32'(io_addr), 32'h04);
      check("ior_c1_we", 32'(io_we), 32'd0);
      check("ior_c1_stall", 32'(stall_M), 32'd1);
      tick(); mid();
      check("ior_c2_req", 32'(io_req), 32'd1);
      check("ior_c2_stall", 32'(stall_M), 32'd1);
      tick(); io_ack = 1'b1; mid();
      check("ior_c3_req", 32'(io_req), 32'd1);
      check("ior_c3_stall", 32'(stall_M), 32'd0);
      check("ior_c3_lvalid", 32'(load_valid_M), 32'd1);
      check("ior_c3_data", load_data_M, 32'h0000_BEEF);
      tick(); txn("IO read 0x00010004");
      idle(); mid();   // ack still high while idle must be ignored
      check("ior_c4_req", 32'(io_req), 32'd0);
      check("ior_stray_ack", 32'(load_valid_M), 32'd0);
      tick(); io_ack = 1'b0;

      // I/O write that never gets acked -> timeout after 5 IO_WAIT cycles
      drive(1'b1, 5'd0, 1'b1, 32'h0001_0080, 32'hCAFE_F00D);
      mid();
      check("iow_c0_stall", 32'(stall_M), 32'd1);
      tick(); mid();
      check("iow_c1_we", 32'(io_we), 32'd1);
      check("iow_c1_addr", 32'(io_addr), 32'h80);
      check("iow_c1_wdata", io_wdata, 32'hCAFE_F00D);
      for (int c = 1; c <= 4; c++) begin
         check($sformatf("iow_c%0d_stall", c), 32'(stall_M), 32'd1);
         check($sformatf("iow_c%0d_req", c), 32'(io_req), 32'd1);
         tick(); mid();
      end
      check("iow_c5_stall", 32'(stall_M), 32'd0);
      check("iow_c5_lvalid", 32'(load_valid_M), 32'd0);
      tick(); txn("IO write 0x00010080 timed out");
      idle(); mid();
      check("iow_timeout", 32'(io_timeout), 32'd1);
      check("iow_req_off", 32'(io_req), 32'd0);
      tick(); tick(); mid();
      check("iow_timeout_sticky", 32'(io_timeout), 32'd1);
      tick();

      // Async reset in RAM_WAIT
      drive(1'b1, OP_LOAD, 1'b0, 32'h0000_0040, 32'd0);
      tick();
      #2 reset = 1'b1; #1;
      check("rst_ram_stall", 32'(stall_M), 32'd0);
      check("rst_ram_lvalid", 32'(load_valid_M), 32'd0);
      idle(); tick(); reset = 1'b0; txn("load dropped by reset");

      // Async reset in IO_WAIT
      drive(1'b1, OP_LOAD, 1'b0, 32'h0001_0008, 32'd0);
      tick(); mid();
      check("pre_rst_io_req", 32'(io_req), 32'd1);
      #1 reset = 1'b1; #1;
      check("rst_io_req_drop", 32'(io_req), 32'd0);
      check("rst_io_stall", 32'(stall_M), 32'd0);
      check("rst_io_timeout_clr", 32'(io_timeout), 32'd0);
      idle(); tick(); reset = 1'b0; txn("IO read dropped by reset");

      // Load after reset completes normally
      drive(1'b1, OP_LOAD, 1'b0, 32'h0000_0044, 32'd0);
      dmem_q = 32'h0;
      mid(); check("post_c0_stall", 32'(stall_M), 32'd1);
      tick(); mid(); check("post_c1_stall", 32'(stall_M), 32'd1);
      tick(); dmem_q = 32'h0BAD_F00D; mid();
      check("post_c2_lvalid", 32'(load_valid_M), 32'd1);
      check("post_c2_data", load_data_M, 32'h0BAD_F00D);
      tick(); txn("RAM load 0x44 after reset");
      idle();

      // Perf counters: 2 loads + 1 RAM store from a fresh reset
      reset = 1'b1; tick(); reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, OP_LOAD, 1'b0, 32'h0000_0050 + 32'(k), 32'd0);
         tick(); tick(); tick();
         txn($sformatf("perf load %0d", k));
      end
      drive(1'b1, 5'd0, 1'b1, 32'h0000_0060, 32'h0000_0077);
      tick(); txn("perf store");
      idle(); mid();
`ifdef DMEM_PERF_COUNT_EN
      check("perf_loads", perf_loads, 32'd2);
      check("perf_stores", perf_stores, 32'd1);
      check("perf_stalls", perf_stalls, 32'd4);
`else
      check("perf_loads", perf_loads, 32'd0);
      check("perf_stores", perf_stores, 32'd0);
      check("perf_stalls", perf_stalls, 32'd0);
`endif
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
